// File: rtl/axis_frame_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_frame_checker_if : AXI4-Stream beat bus (tvalid/tready/tlast)  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface axis_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_frame_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_frame_checker : AXIS sink, backpressure pattern + packet check |
// | Optional first-error capture: define AXIS_CHECK_FIRST_ERR_EN. Rev 1.0|
// +--------------------------------------------------------------------+
module axis_frame_checker #(
  parameter int DATA_W       = 8,
  parameter int FRAME_LEN    = 7,
  parameter int CNT_W        = 16,
  parameter int STALL_PERIOD = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                En,
  axis_frame_checker_if.slave S_AXIS,
  output logic [CNT_W-1:0]    pkt_count,
  output logic [CNT_W-1:0]    err_count,
  output logic                err_data,
  output logic                err_last,
  output logic                busy,
  output logic [CNT_W-1:0]    first_err_pkt,
  output logic [DATA_W-1:0]   first_err_data
);
  localparam int            IW         = $clog2(FRAME_LEN) + 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic             r_pkt_err, w_pkt_err_nxt;
  logic             r_tready, w_stall, w_xfer, w_data_bad, w_last_pos;
  logic             w_beat_err, w_set_data, w_set_last, w_end_pkt, w_end_err;
  logic [CNT_W-1:0] r_pkt_count, r_err_count;
  logic             r_err_data, r_err_last;

  if (STALL_PERIOD > 0) begin : g_stall
    localparam int            SW     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] C_WRAP = SW'(STALL_PERIOD - 1);
    logic [SW-1:0] r_stall_cnt;
    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_stall_cnt <= '0;
      end else if (En) begin
        r_stall_cnt <= (r_stall_cnt == C_WRAP) ? '0 : r_stall_cnt + 1'b1;
      end
    end
    assign w_stall = (r_stall_cnt == C_WRAP);
  end else begin : g_no_stall
    assign w_stall = 1'b0;
  end

  assign w_xfer     = S_AXIS.tvalid & r_tready;
  assign w_data_bad = (S_AXIS.tdata != DATA_W'(r_idx));
  assign w_last_pos = (r_idx == C_LAST_IDX);

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pkt_err_nxt = r_pkt_err;
    w_set_data    = 1'b0;
    w_set_last    = 1'b0;
    w_beat_err    = 1'b0;
    w_end_pkt     = 1'b0;
    w_end_err     = 1'b0;
    if (w_xfer) begin
      case (r_state)
        IDLE, RUN: begin
          w_set_data = w_data_bad;
          // tlast must coincide exactly with the final beat index
          w_set_last = S_AXIS.tlast ^ w_last_pos;
          w_beat_err = w_set_data | w_set_last;
          if (S_AXIS.tlast) begin
            w_end_pkt     = 1'b1;
            w_end_err     = r_pkt_err | w_beat_err;
            w_idx_nxt     = '0;
            w_pkt_err_nxt = 1'b0;
            w_state_nxt   = IDLE;
          end else if (w_last_pos) begin
            w_idx_nxt     = '0;
            w_pkt_err_nxt = 1'b1;
            w_state_nxt   = RESYNC;
          end else begin
            w_idx_nxt     = r_idx + 1'b1;
            w_pkt_err_nxt = r_pkt_err | w_beat_err;
            w_state_nxt   = RUN;
          end
        end
        RESYNC: begin
          if (S_AXIS.tlast) begin
            w_end_pkt     = 1'b1;
            w_end_err     = 1'b1;
            w_pkt_err_nxt = 1'b0;
            w_state_nxt   = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_pkt_err   <= 1'b0;
      r_tready    <= 1'b0;
      r_pkt_count <= '0;
      r_err_count <= '0;
      r_err_data  <= 1'b0;
      r_err_last  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pkt_err <= w_pkt_err_nxt;
      r_tready  <= En & ~w_stall;
      if (w_end_pkt) begin
        if (w_end_err) begin
          if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        end else begin
          if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + 1'b1;
        end
      end
      if (w_set_data) r_err_data <= 1'b1;
      if (w_set_last) r_err_last <= 1'b1;
    end
  end

`ifdef AXIS_CHECK_FIRST_ERR_EN
  logic              r_fe_seen;
  logic [CNT_W-1:0]  r_fe_pkt;
  logic [DATA_W-1:0] r_fe_data;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fe_seen <= 1'b0;
      r_fe_pkt  <= '0;
      r_fe_data <= '0;
    end else if (w_beat_err && !r_fe_seen) begin
      r_fe_seen <= 1'b1;
      r_fe_pkt  <= r_pkt_count + r_err_count;
      r_fe_data <= S_AXIS.tdata;
    end
  end
  assign first_err_pkt  = r_fe_pkt;
  assign first_err_data = r_fe_data;
`else
  assign first_err_pkt  = '0;
  assign first_err_data = '0;
`endif

  assign S_AXIS.tready = r_tready;
  assign pkt_count     = r_pkt_count;
  assign err_count     = r_err_count;
  assign err_data      = r_err_data;
  assign err_last      = r_err_last;
  assign busy          = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_axis_frame_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axis_frame_checker : directed packet vectors for the AXIS checker |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_axis_frame_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  logic [15:0] pkt_a, err_a, fep_a;
  logic [7:0]  fed_a, fed_b;
  logic        ed_a, el_a, busy_a;
  logic [1:0]  pkt_b, err_b, fep_b;
  logic        ed_b, el_b, busy_b;

  axis_frame_checker_if #(.DATA_W(8)) a_if ();
  axis_frame_checker_if #(.DATA_W(8)) b_if ();

  axis_frame_checker #(.DATA_W(8), .FRAME_LEN(7), .CNT_W(16), .STALL_PERIOD(0)) u_dut_a (
    .Clk(clk), .Reset(rst_a), .En(en_a), .S_AXIS(a_if.slave),
    .pkt_count(pkt_a), .err_count(err_a), .err_data(ed_a), .err_last(el_a),
    .busy(busy_a), .first_err_pkt(fep_a), .first_err_data(fed_a));

  axis_frame_checker #(.DATA_W(8), .FRAME_LEN(7), .CNT_W(2), .STALL_PERIOD(4)) u_dut_b (
    .Clk(clk), .Reset(rst_b), .En(en_b), .S_AXIS(b_if.slave),
    .pkt_count(pkt_b), .err_count(err_b), .err_data(ed_b), .err_last(el_b),
    .busy(busy_b), .first_err_pkt(fep_b), .first_err_data(fed_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One beat on DUT A; waits (bounded) until tready will accept it at the next edge
  task automatic a_beat(input int d, input logic l);
    int w;
    @(negedge clk);
    a_if.tvalid = 1'b1;
    a_if.tdata  = d[7:0];
    a_if.tlast  = l;
    w = 0;
    while (!a_if.tready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!a_if.tready) chk("a_tready_timeout", 0, 1);
  endtask

  task automatic a_idle();
    @(negedge clk);
    a_if.tvalid = 1'b0;
    a_if.tlast  = 1'b0;
  endtask

  typedef struct {
    int len; int tl; int bad; int bval;
    int pkt; int err; int ed; int el; int bz;
  } pkt_vec_t;
  pkt_vec_t vecs[8];

  initial begin
    int exp_fep, exp_fed, j, cyc, d;
    vecs[0] = '{7, 6,  2, 9,    0, 1, 1, 0, 0};  // data error on beat 2
    vecs[1] = '{6, 5, -1, 0,    0, 2, 1, 1, 0};  // early tlast
    vecs[2] = '{7, 6, -1, 0,    1, 2, 1, 1, 0};  // good
    vecs[3] = '{9, 8, -1, 0,    1, 3, 1, 1, 0};  // missing tlast, resync 2 beats
    vecs[4] = '{7, 6, -1, 0,    2, 3, 1, 1, 0};
    vecs[5] = '{7, 6, -1, 0,    3, 3, 1, 1, 0};
    vecs[6] = '{7, 6, -1, 0,    4, 3, 1, 1, 0};
    vecs[7] = '{4, 3,  3, 8'h55, 4, 4, 1, 1, 0}; // data + early tlast on one beat
`ifdef AXIS_CHECK_FIRST_ERR_EN
    exp_fep = 0; exp_fed = 9;
`else
    exp_fep = 0; exp_fed = 0;
`endif

    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
    a_if.tvalid = 1'b0; a_if.tlast = 1'b0; a_if.tdata = '0;
    b_if.tvalid = 1'b0; b_if.tlast = 1'b0; b_if.tdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_pkt", pkt_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_flags", {ed_a, el_a, busy_a}, 0);
    chk("rst_tready", a_if.tready, 0);
    chk("rst_first_err", fep_a + fed_a, 0);

    // Stall pattern on DUT B: tready low every 4th cycle after reset release
    rst_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("stall_pattern_%0d", k), b_if.tready, (k % 4 != 0) ? 1 : 0);
    end
    j = 0; cyc = 0;
    while (j < 28 && cyc < 300) begin
      @(negedge clk);
      b_if.tvalid = 1'b1;
      b_if.tdata  = 8'(j % 7);
      b_if.tlast  = (j % 7 == 6);
      if (b_if.tready) j++;
      cyc++;
    end
    if (j < 28) chk("b_stream_timeout", j, 28);
    @(negedge clk);
    b_if.tvalid = 1'b0; b_if.tlast = 1'b0;
    chk("stall_pkt_saturated", pkt_b, 3);
    chk("stall_err", err_b, 0);
    chk("stall_flags", {ed_b, el_b}, 0);

    // Table-driven packets on DUT A
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < vecs[i].len; b++) begin
        d = (b == vecs[i].bad) ? vecs[i].bval : b;
        a_beat(d, b == vecs[i].tl);
      end
      a_idle();
      chk($sformatf("v%0d_pkt", i), pkt_a, vecs[i].pkt);
      chk($sformatf("v%0d_err", i), err_a, vecs[i].err);
      chk($sformatf("v%0d_err_data", i), ed_a, vecs[i].ed);
      chk($sformatf("v%0d_err_last", i), el_a, vecs[i].el);
      chk($sformatf("v%0d_busy", i), busy_a, vecs[i].bz);
    end
    chk("first_err_pkt", fep_a, exp_fep);
    chk("first_err_data", fed_a, exp_fed);

    // Missing tlast leaves the checker busy until the resync tlast
    for (int b = 0; b < 7; b++) a_beat(b, 1'b0);
    a_idle();
    chk("resync_busy", busy_a, 1);
    a_beat(0, 1'b1);
    a_idle();
    chk("resync_done_busy", busy_a, 0);
    chk("resync_err", err_a, 5);

    // Reset mid-packet abandons it
    for (int b = 0; b < 4; b++) a_beat(b, 1'b0);
    a_idle();
    chk("mid_busy", busy_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_counts", pkt_a + err_a, 0);
    chk("mid_rst_flags", {ed_a, el_a, busy_a, a_if.tready}, 0);
    chk("mid_rst_first_err", fep_a + fed_a, 0);
    rst_a = 1'b0;
    for (int b = 0; b < 7; b++) a_beat(b, b == 6);
    a_idle();
    chk("post_rst_pkt", pkt_a, 1);
    chk("post_rst_err", err_a, 0);
    chk("post_rst_flags", {ed_a, el_a}, 0);

    // En low: tready drops on the next cycle and nothing is accepted
    chk("en_tready_before", a_if.tready, 1);
    en_a = 1'b0;
    @(negedge clk);
    chk("en_tready_after", a_if.tready, 0);
    a_if.tvalid = 1'b1; a_if.tdata = 8'd0; a_if.tlast = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_off_pkt", pkt_a, 1);
    chk("en_off_busy", busy_a, 0);
    a_if.tvalid = 1'b0; a_if.tlast = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
